// File: rtl/stopwatch_core.sv
// mm:ss.hh BCD stopwatch fed by a synchronised 10 kHz tick, prescaled to 0.01 s steps.
// Optional lap freeze of the displayed value when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int TICKS_PER_HUNDREDTH = 100,
  parameter int MAX_MINUTES         = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] bcd_time,
  output logic        running,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICKS_PER_HUNDREDTH - 1);
  localparam logic [3:0]  MAX_MIN_T = 4'(MAX_MINUTES / 10);
  localparam logic [3:0]  MAX_MIN_O = 4'(MAX_MINUTES % 10);

  state_t      state_q, state_d;
  logic        running_q, running_d;
  logic        overflow_q, overflow_d;
  logic        sync1_q, sync2_q, dly_q;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  mt_q, mo_q, st_q, so_q, ht_q, ho_q;
  logic [3:0]  mt_d, mo_d, st_d, so_d, ht_d, ho_d;
  logic [23:0] live_time;

  logic tick_rise, clr_now, count_en, advance;
  logic c_ho, c_ht, c_so, c_st, wrap;

  assign tick_rise = sync2_q & ~dly_q;
  assign clr_now   = clear && (state_q != RUN);
  // A tick coinciding with RUN->PAUSED is dropped; PAUSED->RUN is excluded by state_q.
  assign count_en  = (state_q == RUN) && tick_rise && !start_stop;
  assign advance   = count_en && (presc_q == PRESC_MAX);

  assign c_ho = (ho_q == 4'd9);
  assign c_ht = c_ho && (ht_q == 4'd9);
  assign c_so = c_ht && (so_q == 4'd9);
  assign c_st = c_so && (st_q == 4'd5);
  assign wrap = c_st && (mt_q == MAX_MIN_T) && (mo_q == MAX_MIN_O);

  assign live_time = {mt_q, mo_q, st_q, so_q, ht_q, ho_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = IDLE;
               else if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSED;
      PAUSED:  if (clear) state_d = IDLE;
               else if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  always_comb begin
    presc_d    = presc_q;
    overflow_d = 1'b0;
    mt_d = mt_q; mo_d = mo_q; st_d = st_q;
    so_d = so_q; ht_d = ht_q; ho_d = ho_q;
    if (clr_now) begin
      presc_d = '0;
      mt_d = '0; mo_d = '0; st_d = '0;
      so_d = '0; ht_d = '0; ho_d = '0;
    end else if (count_en) begin
      presc_d = advance ? 16'd0 : presc_q + 16'd1;
      if (advance) begin
        ho_d = c_ho ? 4'd0 : ho_q + 4'd1;
        if (c_ho) ht_d = c_ht ? 4'd0 : ht_q + 4'd1;
        if (c_ht) so_d = c_so ? 4'd0 : so_q + 4'd1;
        if (c_so) st_d = c_st ? 4'd0 : st_q + 4'd1;
        if (c_st) begin
          if (wrap) begin
            mt_d       = 4'd0;
            mo_d       = 4'd0;
            overflow_d = 1'b1;
          end else if (mo_q == 4'd9) begin
            mo_d = 4'd0;
            mt_d = mt_q + 4'd1;
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      presc_q    <= '0;
      mt_q <= '0; mo_q <= '0; st_q <= '0;
      so_q <= '0; ht_q <= '0; ho_q <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
      sync1_q    <= tick_in;
      sync2_q    <= sync1_q;
      dly_q      <= sync2_q;
      presc_q    <= presc_d;
      mt_q <= mt_d; mo_q <= mo_d; st_q <= st_d;
      so_q <= so_d; ht_q <= ht_d; ho_q <= ho_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        frozen_q, frozen_d;
  logic [23:0] snap_q, snap_d;

  // Snapshot is taken of the value on display at the lap edge.
  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (clear) begin
      frozen_d = 1'b0;
    end else if (lap) begin
      if (state_q == RUN) begin
        frozen_d = !frozen_q;
        if (!frozen_q) snap_d = live_time;
      end else begin
        frozen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign bcd_time = frozen_q ? snap_q : live_time;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign bcd_time   = live_time;
`endif

  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: three instances with different prescale/wrap settings
// share stimulus; each scenario task checks the instance it targets.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [23:0] bt_a, bt_b, bt_c;
  logic        run_a, run_b, run_c;
  logic        ov_a, ov_b, ov_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.TICKS_PER_HUNDREDTH(2), .MAX_MINUTES(59)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
    .lap(lap), .bcd_time(bt_a), .running(run_a), .overflow(ov_a));

  stopwatch_core #(.TICKS_PER_HUNDREDTH(1), .MAX_MINUTES(1)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
    .lap(lap), .bcd_time(bt_b), .running(run_b), .overflow(ov_b));

  stopwatch_core #(.TICKS_PER_HUNDREDTH(4), .MAX_MINUTES(59)) dut_c (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
    .lap(lap), .bcd_time(bt_c), .running(run_c), .overflow(ov_c));

  // All stimulus changes and samples happen at negedge, away from the active edge.
  task automatic tick_edge();
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bt_a, bt_b, bt_c} !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_time: got %h %h %h want 0", bt_a, bt_b, bt_c);
    end
    vectors++;
    if ({run_a, run_b, run_c, ov_a, ov_b, ov_c} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000", {run_a, run_b, run_c, ov_a, ov_b, ov_c});
    end
  endtask

  task automatic test_prescale_latency();
    do_reset();
    start_stop = 1'b1;
    vectors++;
    if (run_a !== 1'b0) begin
      miscompares++;
      $display("FAIL run_before_edge: got %b want 0", run_a);
    end
    @(negedge clk);
    start_stop = 1'b0;
    vectors++;
    if (run_a !== 1'b1) begin
      miscompares++;
      $display("FAIL run_after_start: got %b want 1", run_a);
    end
    tick_edge();
    vectors++;
    if (bt_a !== 24'h000000) begin
      miscompares++;
      $display("FAIL presc_first_edge: got %h want 000000", bt_a);
    end
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bt_a !== 24'h000000) begin
      miscompares++;
      $display("FAIL latency_early: got %h want 000000", bt_a);
    end
    @(negedge clk);
    vectors++;
    if (bt_a !== 24'h000001) begin
      miscompares++;
      $display("FAIL latency_update: got %h want 000001", bt_a);
    end
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    ticks(2);
    vectors++;
    if (bt_a !== 24'h000002) begin
      miscompares++;
      $display("FAIL four_edges: got %h want 000002", bt_a);
    end
  endtask

  task automatic test_carry_and_overflow();
    int ovc;
    do_reset();
    pulse_ss();
    ticks(999);
    vectors++;
    if (bt_b !== 24'h000999) begin
      miscompares++;
      $display("FAIL carry_pre: got %h want 000999", bt_b);
    end
    tick_edge();
    vectors++;
    if (bt_b !== 24'h001000) begin
      miscompares++;
      $display("FAIL carry_sec: got %h want 001000", bt_b);
    end
    ticks(5000);
    vectors++;
    if (bt_b !== 24'h010000) begin
      miscompares++;
      $display("FAIL carry_min: got %h want 010000", bt_b);
    end
    ticks(5999);
    vectors++;
    if (bt_b !== 24'h015999 || ov_b !== 1'b0) begin
      miscompares++;
      $display("FAIL max_time: got %h ov %b want 015999 ov 0", bt_b, ov_b);
    end
    ovc = 0;
    tick_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) tick_in = 1'b0;
      if (ov_b === 1'b1) ovc++;
    end
    vectors++;
    if (ovc !== 1) begin
      miscompares++;
      $display("FAIL overflow_width: got %0d cycles want 1", ovc);
    end
    vectors++;
    if (bt_b !== 24'h000000 || run_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: got %h run %b want 000000 run 1", bt_b, run_b);
    end
  endtask

  task automatic test_pause_clear();
    do_reset();
    pulse_ss();
    ticks(6);
    vectors++;
    if (bt_c !== 24'h000001) begin
      miscompares++;
      $display("FAIL pause_pre: got %h want 000001", bt_c);
    end
    pulse_ss();
    ticks(10);
    vectors++;
    if (bt_c !== 24'h000001 || run_c !== 1'b0) begin
      miscompares++;
      $display("FAIL paused_hold: got %h run %b want 000001 run 0", bt_c, run_c);
    end
    pulse_ss();
    ticks(2);
    vectors++;
    if (bt_c !== 24'h000002) begin
      miscompares++;
      $display("FAIL resume_remainder: got %h want 000002", bt_c);
    end
    pulse_clear();
    vectors++;
    if (bt_c !== 24'h000002 || run_c !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_in_run: got %h run %b want 000002 run 1", bt_c, run_c);
    end
    tick_edge();
    pulse_ss();
    pulse_clear();
    vectors++;
    if (bt_c !== 24'h000000 || run_c !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_paused: got %h run %b want 000000 run 0", bt_c, run_c);
    end
    pulse_ss();
    ticks(3);
    vectors++;
    if (bt_c !== 24'h000000) begin
      miscompares++;
      $display("FAIL presc_cleared: got %h want 000000", bt_c);
    end
    tick_edge();
    vectors++;
    if (bt_c !== 24'h000001) begin
      miscompares++;
      $display("FAIL presc_restart: got %h want 000001", bt_c);
    end
  endtask

  task automatic test_simultaneous_and_rst();
    do_reset();
    pulse_ss();
    ticks(15);
    pulse_ss();
    vectors++;
    if (bt_b !== 24'h000015) begin
      miscompares++;
      $display("FAIL sim_pre: got %h want 000015", bt_b);
    end
    start_stop = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    clear = 1'b0;
    vectors++;
    if (bt_b !== 24'h000000 || run_b !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_paused: got %h run %b want 000000 run 0", bt_b, run_b);
    end
    pulse_ss();
    ticks(3);
    start_stop = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    clear = 1'b0;
    vectors++;
    if (bt_b !== 24'h000003 || run_b !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_run: got %h run %b want 000003 run 0", bt_b, run_b);
    end
    ticks(2);
    vectors++;
    if (bt_b !== 24'h000003) begin
      miscompares++;
      $display("FAIL sim_run_paused: got %h want 000003", bt_b);
    end
    pulse_ss();
    tick_edge();
    vectors++;
    if (bt_b !== 24'h000004 || run_b !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: got %h run %b want 000004 run 1", bt_b, run_b);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bt_b !== 24'h000000 || run_b !== 1'b0 || ov_b !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_run: got %h run %b ov %b want 000000 0 0", bt_b, run_b, ov_b);
    end
  endtask

  task automatic test_lap();
    logic [23:0] exp_frozen;
    do_reset();
    pulse_ss();
    ticks(100);
    vectors++;
    if (bt_b !== 24'h000100) begin
      miscompares++;
      $display("FAIL lap_pre: got %h want 000100", bt_b);
    end
    pulse_lap();
    ticks(50);
`ifdef STOPWATCH_LAP_EN
    exp_frozen = 24'h000100;
`else
    exp_frozen = 24'h000150;
`endif
    vectors++;
    if (bt_b !== exp_frozen) begin
      miscompares++;
      $display("FAIL lap_hold: got %h want %h", bt_b, exp_frozen);
    end
    pulse_lap();
    vectors++;
    if (bt_b !== 24'h000150) begin
      miscompares++;
      $display("FAIL lap_release: got %h want 000150", bt_b);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_prescale_latency();
    test_carry_and_overflow();
    test_pause_clear();
    test_simultaneous_and_rst();
    test_lap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
